// File: rtl/gdp_pkg.sv
// Shared types and helpers for the Gaussian-distance scoring engine family.
// Holds the engine state enum, the default fixed-point format and the saturation helper.
package gdp_pkg;

   localparam int W_DEFAULT    = 16;
   localparam int FRAC_DEFAULT = 8;

   typedef logic signed [W_DEFAULT-1:0] num_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Clamp a wide signed value into the range of a w-bit signed number.
   function automatic logic signed [127:0] sat_w(input logic signed [127:0] v, input int w);
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      hi = (128'sd1 <<< (w - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/gdp_term.sv
// Combinational weighted squared-distance term for one component:
// term = ((x - mean)^2 * omega) >> (2*FRAC), all intermediate widths lossless.
module gdp_term
   import gdp_pkg::*;
#(
   parameter int W    = W_DEFAULT,
   parameter int FRAC = FRAC_DEFAULT
) (
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   mean,
   input  logic [W-1:0]   omega,
   output logic [3*W+1:0] term
);

   logic signed [W:0] d;
   logic [W:0]        d_mag;
   logic [2*W+1:0]    sq;
   logic [3*W+1:0]    prod;

   assign d     = $signed({x[W-1], x}) - $signed({mean[W-1], mean});
   // Squaring the magnitude keeps the multiply unsigned.
   assign d_mag = d[W] ? $unsigned(-d) : $unsigned(d);
   assign sq    = (2*W+2)'(d_mag) * (2*W+2)'(d_mag);
   assign prod  = (3*W+2)'(sq) * (3*W+2)'(omega);
   assign term  = prod >> (2*FRAC);

endmodule

// File: rtl/gdp_score_engine.sv
// Senone scoring engine: latches an observation, streams per-component stats, emits one
// saturated score per senone. Define GDP_BEST_TRACK_EN to add best_score/best_index outputs.
module gdp_score_engine
   import gdp_pkg::*;
#(
   parameter int N_COMP    = 25,
   parameter int N_SENONES = 256,
   parameter int W         = 16,
   parameter int FRAC      = FRAC_DEFAULT,
   localparam int CW       = (N_COMP > 1) ? $clog2(N_COMP) : 1,
   localparam int SW       = (N_SENONES > 1) ? $clog2(N_SENONES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_COMP*W-1:0] x_flat,
   input  logic              x_valid,
   output logic              x_ready,
   input  logic              stat_valid,
   output logic              stat_ready,
   input  logic [W-1:0]      stat_mean,
   input  logic [W-1:0]      stat_omega,
   input  logic [W-1:0]      stat_k,
   output logic [CW-1:0]     comp_index,
   output logic [SW-1:0]     senone_index,
   output logic [W-1:0]      score,
   output logic [SW-1:0]     score_index,
   output logic              score_valid,
   input  logic              score_ready,
   output logic              busy,
   output logic              frame_done
`ifdef GDP_BEST_TRACK_EN
   ,
   output logic [W-1:0]      best_score,
   output logic [SW-1:0]     best_index
`endif
);

   localparam int TERM_W = 3*W + 2;
   localparam int ACC_W  = TERM_W + CW;
   localparam int DIFF_W = ACC_W + 2;

   state_t state_reg, state_next;

   logic [W-1:0]      x_in [N_COMP];
   logic [W-1:0]      x_reg [N_COMP];
   logic [W-1:0]      x_cur;
   logic [CW-1:0]     comp_reg;
   logic [SW-1:0]     senone_reg;
   logic [ACC_W-1:0]  acc_reg;
   logic [W-1:0]      k_reg;
   logic [W-1:0]      score_reg;
   logic [SW-1:0]     score_index_reg;
   logic              score_valid_reg;
   logic              frame_done_reg;

   logic [TERM_W-1:0]        term;
   logic [ACC_W-1:0]         acc_sum;
   logic [W-1:0]             k_eff;
   logic signed [DIFF_W-1:0] diff;
   logic [W-1:0]             score_next;
   logic first_comp, last_comp, last_senone;
   logic x_fire, stat_fire, score_fire;

   for (genvar gi = 0; gi < N_COMP; gi++) begin : g_x_slice
      assign x_in[gi] = x_flat[gi*W +: W];
   end

   assign x_cur = x_reg[comp_reg];

   gdp_term #(.W(W), .FRAC(FRAC)) u_term (
      .x     (x_cur),
      .mean  (stat_mean),
      .omega (stat_omega),
      .term  (term)
   );

   assign first_comp  = (comp_reg == '0);
   assign last_comp   = (comp_reg == CW'(N_COMP - 1));
   assign last_senone = (senone_reg == SW'(N_SENONES - 1));

   assign x_fire     = x_valid && x_ready;
   assign stat_fire  = stat_valid && stat_ready;
   assign score_fire = score_valid_reg && score_ready;

   // Component 0 restarts the sum and supplies k, so a single-component senone still works.
   assign acc_sum    = (first_comp ? '0 : acc_reg) + ACC_W'(term);
   assign k_eff      = first_comp ? stat_k : k_reg;
   assign diff       = DIFF_W'($signed(k_eff)) - $signed({2'b00, acc_sum});
   assign score_next = W'(sat_w(128'(diff), W));

   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (x_fire) state_next = ST_RUN;
         ST_RUN:   if (stat_fire && last_comp && last_senone) state_next = ST_FLUSH;
         ST_FLUSH: if (score_fire) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      x_ready    = (state_reg == ST_IDLE);
      busy       = (state_reg != ST_IDLE);
      // A pending score that is not being taken this cycle blocks the next result.
      stat_ready = (state_reg == ST_RUN) && !(score_valid_reg && !score_ready);
   end

   always_ff @(posedge clk) begin
      if (x_fire) x_reg <= x_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         comp_reg        <= '0;
         senone_reg      <= '0;
         acc_reg         <= '0;
         k_reg           <= '0;
         score_reg       <= '0;
         score_index_reg <= '0;
         score_valid_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
      end else begin
         frame_done_reg <= (state_reg == ST_FLUSH) && score_fire;
         if (score_fire) score_valid_reg <= 1'b0;
         if (x_fire) begin
            comp_reg   <= '0;
            senone_reg <= '0;
            acc_reg    <= '0;
         end
         if (stat_fire) begin
            acc_reg <= acc_sum;
            if (first_comp) k_reg <= stat_k;
            if (last_comp) begin
               comp_reg        <= '0;
               senone_reg      <= last_senone ? '0 : senone_reg + 1'b1;
               score_reg       <= score_next;
               score_index_reg <= senone_reg;
               score_valid_reg <= 1'b1;
            end else begin
               comp_reg <= comp_reg + 1'b1;
            end
         end
      end
   end

   assign comp_index   = comp_reg;
   assign senone_index = senone_reg;
   assign score        = score_reg;
   assign score_index  = score_index_reg;
   assign score_valid  = score_valid_reg;
   assign frame_done   = frame_done_reg;

`ifdef GDP_BEST_TRACK_EN
   logic signed [W-1:0] best_score_reg;
   logic [SW-1:0]       best_index_reg;

   // Strict compare while scanning upward keeps the lower index on ties.
   always_ff @(posedge clk) begin
      if (reset || x_fire) begin
         best_score_reg <= {1'b1, {(W-1){1'b0}}};
         best_index_reg <= '0;
      end else if (stat_fire && last_comp && ($signed(score_next) > best_score_reg)) begin
         best_score_reg <= score_next;
         best_index_reg <= senone_reg;
      end
   end

   assign best_score = best_score_reg;
   assign best_index = best_index_reg;
`endif

endmodule

// File: tb/tb_gdp_score_engine.sv
// Scoreboard bench for gdp_score_engine: a driver streams frames and queues expected
// scores from an arithmetic reference model; a monitor pops and compares on each accepted score.
module tb_gdp_score_engine;

   localparam int N_COMP = 4, N_SENONES = 3, W = 16, FRAC = 8, CW = 2, SW = 2;

   logic clk = 1'b0;
   logic reset;
   logic [N_COMP*W-1:0] x_flat;
   logic x_valid, x_ready, stat_valid, stat_ready;
   logic [W-1:0] stat_mean, stat_omega, stat_k, score;
   logic [CW-1:0] comp_index;
   logic [SW-1:0] senone_index, score_index;
   logic score_valid, score_ready, busy, frame_done;
`ifdef GDP_BEST_TRACK_EN
   logic [W-1:0]  best_score;
   logic [SW-1:0] best_index;
`endif

   always #5 clk = ~clk;

   gdp_score_engine #(.N_COMP(N_COMP), .N_SENONES(N_SENONES), .W(W), .FRAC(FRAC)) dut (
      .clk(clk), .reset(reset), .x_flat(x_flat), .x_valid(x_valid), .x_ready(x_ready),
      .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_mean(stat_mean),
      .stat_omega(stat_omega), .stat_k(stat_k), .comp_index(comp_index),
      .senone_index(senone_index), .score(score), .score_index(score_index),
      .score_valid(score_valid), .score_ready(score_ready), .busy(busy),
      .frame_done(frame_done)
`ifdef GDP_BEST_TRACK_EN
      , .best_score(best_score), .best_index(best_index)
`endif
   );

   typedef struct { int score; int idx; } exp_t;
   exp_t exp_q[$];

   int fx[N_COMP];
   int fmean[N_SENONES][N_COMP];
   int fomega[N_SENONES][N_COMP];
   int fk[N_SENONES];
   int checks = 0, errors = 0, done_cnt = 0, ready_mode = 0, stall_cnt = 0;
   int exp_best_score, exp_best_idx;

   task automatic check(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Reference: score = k - sum(((x-mean)^2 * omega) >> 16), clamped to 16-bit signed.
   function automatic int ref_score(int s);
      longint acc = 0;
      longint d, v;
      for (int c = 0; c < N_COMP; c++) begin
         d = longint'(fx[c]) - longint'(fmean[s][c]);
         acc += (d * d * longint'(fomega[s][c])) >>> (2 * FRAC);
      end
      v = longint'(fk[s]) - acc;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return int'(v);
   endfunction

   task automatic build_expected();
      exp_t e;
      exp_best_score = -32768;
      exp_best_idx   = 0;
      for (int s = 0; s < N_SENONES; s++) begin
         e.score = ref_score(s);
         e.idx   = s;
         exp_q.push_back(e);
         if (e.score > exp_best_score) begin
            exp_best_score = e.score;
            exp_best_idx   = s;
         end
      end
   endtask

   task automatic set_uniform(input int xv, input int mv, input int ov, input int kv);
      for (int s = 0; s < N_SENONES; s++) begin
         fk[s] = kv;
         for (int c = 0; c < N_COMP; c++) begin
            fx[c] = xv;
            fmean[s][c] = mv;
            fomega[s][c] = ov;
         end
      end
   endtask

   task automatic set_random(input bit full);
      for (int c = 0; c < N_COMP; c++)
         fx[c] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 2047)) - 1024;
      for (int s = 0; s < N_SENONES; s++) begin
         fk[s] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 16383)) - 4096;
         for (int c = 0; c < N_COMP; c++) begin
            fmean[s][c]  = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 2047)) - 1024;
            fomega[s][c] = full ? int'($urandom_range(0, 32767)) : int'($urandom_range(0, 511));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values();
      @(negedge clk);
      check("rst_x_ready", x_ready, 1);
      check("rst_stat_ready", stat_ready, 0);
      check("rst_score_valid", score_valid, 0);
      check("rst_score", score, 0);
      check("rst_score_index", score_index, 0);
      check("rst_comp_index", comp_index, 0);
      check("rst_senone_index", senone_index, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic stalled = 1'b0;
      int ps = 0, pi = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            stalled = 1'b0;
            continue;
         end
         if (stalled) begin
            check("hold_valid", score_valid, 1);
            check("hold_score", $signed(score), ps);
            check("hold_index", score_index, pi);
         end
         stalled = 1'b0;
         if (score_valid && score_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_score", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("score", $signed(score), e.score);
               check("score_index", score_index, e.idx);
            end
         end else if (score_valid) begin
            check("stall_stat_ready", stat_ready, 0);
            stalled = 1'b1;
            ps = $signed(score);
            pi = score_index;
         end
         if (frame_done) begin
            done_cnt++;
            check("done_queue_empty", exp_q.size(), 0);
            check("done_x_ready", x_ready, 1);
            check("done_busy", busy, 0);
         end
      end
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: score_ready = 1'b1;
            1: score_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (score_valid && score_index == 0 && stall_cnt < 5) begin
                  score_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  score_ready = 1'b1;
               end
            end
         endcase
      end
   endtask

   task automatic run_frame(input bit gaps, input bit xjunk, input bit abort);
      int wcnt;
      int d0;
      build_expected();
      d0 = done_cnt;
      for (int i = 0; i < N_COMP; i++) x_flat[i*W +: W] = 16'(fx[i]);
      x_valid = 1'b1;
      @(negedge clk);
      check("x_ready_idle", x_ready, 1);
      tick();
      x_valid = 1'b0;
      if (xjunk) begin
         x_valid = 1'b1;
         x_flat  = {$urandom, $urandom};
      end
      for (int s = 0; s < N_SENONES; s++) begin
         for (int c = 0; c < N_COMP; c++) begin
            if (s == 1 && c == 0) x_valid = 1'b0;
            if (abort && s == 1 && c == 2) begin
               stat_valid = 1'b0;
               reset = 1'b1;
               tick();
               check_reset_values();
               exp_q.delete();
               reset = 1'b0;
               repeat (10) tick();
               check("abort_no_done", done_cnt, d0);
               return;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
               stat_valid = 1'b0;
               repeat ($urandom_range(1, 3)) begin
                  @(negedge clk);
                  check("gap_comp_hold", comp_index, c);
                  if (x_valid) check("x_ready_busy", x_ready, 0);
                  tick();
               end
            end
            stat_valid = 1'b1;
            stat_mean  = 16'(fmean[s][c]);
            stat_omega = 16'(fomega[s][c]);
            stat_k     = (c == 0) ? 16'(fk[s]) : 16'($urandom);
            wcnt = 0;
            forever begin
               @(negedge clk);
               if (stat_ready) break;
               tick();
               wcnt++;
               if (wcnt > 100) begin
                  check("stat_ready_timeout", wcnt, 0);
                  stat_valid = 1'b0;
                  return;
               end
            end
            check("comp_index", comp_index, c);
            check("senone_index", senone_index, s);
            if (x_valid) check("x_ready_busy", x_ready, 0);
            tick();
            if (c == N_COMP - 1) begin
               check("latency_valid", score_valid, 1);
               check("latency_index", score_index, s);
            end
         end
      end
      stat_valid = 1'b0;
      wcnt = 0;
      while (done_cnt == d0 && wcnt < 200) begin
         tick();
         wcnt++;
      end
      check("frame_done_count", done_cnt, d0 + 1);
`ifdef GDP_BEST_TRACK_EN
      check("best_score", $signed(best_score), exp_best_score);
      check("best_index", best_index, exp_best_idx);
`endif
      repeat (2) tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      x_valid = 1'b0;
      x_flat = '0;
      stat_valid = 1'b0;
      stat_mean = '0;
      stat_omega = '0;
      stat_k = '0;
      score_ready = 1'b1;
      fork
         monitor();
         ready_driver();
      join_none
      repeat (3) tick();
      check_reset_values();
      reset = 1'b0;
      tick();

      set_uniform(16'h0200, 16'h0100, 16'h0100, 16'h0A00);
      ready_mode = 0;
      run_frame(0, 0, 0);

      ready_mode = 2;
      stall_cnt = 0;
      run_frame(0, 0, 0);

      ready_mode = 0;
      set_uniform(32767, -32768, 32767, 0);
      run_frame(0, 0, 0);

      set_uniform(16'h0200, 16'h0100, 16'h0100, 16'h0A00);
      run_frame(0, 0, 1);
      run_frame(0, 0, 0);

      ready_mode = 1;
      run_frame(1, 1, 0);

      ready_mode = 0;
      fk[0] = 16'h0100;
      fk[1] = 16'h0A00;
      fk[2] = 16'h0A00;
      run_frame(0, 0, 0);

      ready_mode = 1;
      for (int f = 0; f < 6; f++) begin
         set_random(f[0]);
         run_frame(1, f[1], 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
